// File: rtl/pos_cell_access_ctrl.sv
// Single-owner port controller for one per-cell position RAM: streams a whole
// cell (count word, then words 1..N) to the force reader, and grants motion-update writes when idle.
module pos_cell_access_ctrl #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_start,
  output logic                  rd_busy,
  output logic                  rd_out_valid,
  output logic [DATA_WIDTH-1:0] rd_out_data,
  output logic                  rd_out_last,
  output logic                  rd_done,
  output logic [ADDR_WIDTH-1:0] rd_count,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_grant,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic [2:0] {
    IDLE,
    RD_CNT,
    RD_WAIT,
    RD_STREAM,
    RD_DRAIN
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  state_t                state;
  logic                  wait_cnt;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] next_ptr;
  logic [ADDR_WIDTH-1:0] cnt_raw;
  logic [ADDR_WIDTH-1:0] cnt_clamped;
  // Tags travelling with the read on the RAM port, then two stages to meet mem_q
  logic                  issue_stream;
  logic                  issue_last;
  logic                  valid_s1;
  logic                  last_s1;

  assign wr_grant    = wr_req & (state == IDLE) & ~rd_start;
  assign rd_out_data = mem_q;
  assign next_ptr    = rd_ptr + 1'b1;

  always_comb begin
    cnt_raw     = mem_q[ADDR_WIDTH-1:0];
    cnt_clamped = (cnt_raw > MAX_CNT) ? MAX_CNT : cnt_raw;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= 1'b0;
      rd_ptr       <= '0;
      issue_stream <= 1'b0;
      issue_last   <= 1'b0;
      valid_s1     <= 1'b0;
      last_s1      <= 1'b0;
      rd_busy      <= 1'b0;
      rd_out_valid <= 1'b0;
      rd_out_last  <= 1'b0;
      rd_done      <= 1'b0;
      rd_count     <= '0;
      mem_address  <= '0;
      mem_data     <= '0;
      mem_rden     <= 1'b0;
      mem_wren     <= 1'b0;
    end else begin
      mem_rden     <= 1'b0;
      mem_wren     <= 1'b0;
      issue_stream <= 1'b0;
      issue_last   <= 1'b0;
      valid_s1     <= issue_stream;
      last_s1      <= issue_last;
      rd_out_valid <= valid_s1;
      rd_out_last  <= last_s1;
      // Completion follows the last beat; the empty-cell case overrides below
      rd_done      <= last_s1;

      case (state)
        IDLE: begin
          if (rd_start) begin
            state       <= RD_CNT;
            rd_busy     <= 1'b1;
            mem_rden    <= 1'b1;
            mem_address <= '0;
          end else if (wr_req) begin
            mem_wren    <= 1'b1;
            mem_address <= wr_addr;
            mem_data    <= wr_data;
          end
        end

        RD_CNT: begin
          state    <= RD_WAIT;
          wait_cnt <= 1'b0;
        end

        RD_WAIT: begin
          if (!wait_cnt) begin
            wait_cnt <= 1'b1;
          end else begin
            rd_count <= cnt_clamped;
            if (cnt_clamped == '0) begin
              rd_done <= 1'b1;
              state   <= RD_DRAIN;
            end else begin
              state        <= RD_STREAM;
              rd_ptr       <= ADDR_WIDTH'(1);
              mem_rden     <= 1'b1;
              mem_address  <= ADDR_WIDTH'(1);
              issue_stream <= 1'b1;
              issue_last   <= (cnt_clamped == ADDR_WIDTH'(1));
            end
          end
        end

        RD_STREAM: begin
          if (rd_ptr == rd_count) begin
            state <= RD_DRAIN;
          end else begin
            rd_ptr       <= next_ptr;
            mem_rden     <= 1'b1;
            mem_address  <= next_ptr;
            issue_stream <= 1'b1;
            issue_last   <= (next_ptr == rd_count);
          end
        end

        RD_DRAIN: begin
          if (rd_done) begin
            state   <= IDLE;
            rd_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          rd_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pos_cell_access_ctrl.md
Name: pos_cell_access_ctrl

Overview: Single-owner controller for one per-cell position RAM (single-port, 2-cycle read latency, word 0 = particle count, words 1..N = {posz,posy,posx}). Shares the port between the force-evaluation reader and the motion-update writer. Streams a whole cell to the reader: it fetches the count, then issues reads 1..N. Sits between the position cache and each cell RAM instance.

Parameters:
DATA_WIDTH, 96, RAM word width ({posz,posy,posx}, 32 bits each)
PARTICLE_NUM, 220, RAM depth in words, count word included
ADDR_WIDTH, 8, RAM address width

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
rd_start  input  1  one-cycle pulse: stream the whole cell to the reader
rd_busy  output  1  read sequence in progress
rd_out_valid  output  1  rd_out_data holds a particle word
rd_out_data  output  DATA_WIDTH  particle word; combinational from mem_q
rd_out_last  output  1  qualifies the final particle word
rd_done  output  1  one-cycle pulse when the sequence completes
rd_count  output  ADDR_WIDTH  clamped count from the last sequence
wr_req  input  1  write request; held high until granted
wr_addr  input  ADDR_WIDTH  write address (0 = count word)
wr_data  input  DATA_WIDTH  write data
wr_grant  output  1  combinational; write accepted this cycle
mem_address  output  ADDR_WIDTH  to RAM address
mem_data  output  DATA_WIDTH  to RAM data
mem_rden  output  1  to RAM rden
mem_wren  output  1  to RAM wren
mem_q  input  DATA_WIDTH  from RAM q, valid 2 cycles after rden issue

Behaviour:
- Reset: state IDLE; all registered outputs are 0 (rd_busy, rd_out_valid, rd_out_last, rd_done, rd_count, mem_*). The read-valid pipeline is cleared. In-flight reads are discarded, with no valid or done emitted for them. Reset has priority over all inputs.
- mem_address, mem_data, mem_rden and mem_wren are registered. Each command is driven during the cycle after it is decided. At most one command is issued per cycle.
- States:
  - IDLE.
  - RD_CNT: issue read at address 0.
  - RD_WAIT: 2 cycles, then capture the count.
  - RD_STREAM: issue reads at addresses 1..N.
  - RD_DRAIN: wait for the last 2 data cycles.
- IDLE arbitration:
  - rd_start wins over wr_req. While rd_start=1, wr_grant=0.
  - wr_grant = wr_req & IDLE & ~rd_start. A granted write drives mem_wren=1 with wr_addr/wr_data in the next cycle.
  - Back-to-back writes are allowed, one per cycle.
- A write and a read can never collide. Both decisions are made in IDLE in the same cycle and are mutually exclusive.
- Read timeline (rd_start sampled at cycle T):
  - T+1: mem_rden=1, address 0; rd_busy=1 from T+1.
  - T+3: mem_q holds the count word.
  - Count N = mem_q[ADDR_WIDTH-1:0], clamped to PARTICLE_NUM-1. It is registered at the end of T+3 into rd_count.
  - T+3+k: read issued at address k (k = 1..N).
  - T+5+k: rd_out_valid=1 and rd_out_data = mem_q for address k. rd_out_valid is aligned through a 2-stage valid shift register.
  - T+5+N: rd_out_last=1 and rd_done=1.
  - T+6+N: rd_busy=0; the block is in IDLE and can accept a new rd_start or grant a write that cycle.
- N=0: no stream reads and no rd_out_valid. rd_done pulses at T+4 (rd_out_last stays 0). rd_busy=0 at T+5.
- rd_start while rd_busy=1 is ignored, with no queuing.
- wr_req during a read sequence stays ungranted until IDLE. Data is never dropped.
- Address arithmetic: the stream counter is ADDR_WIDTH wide and never exceeds PARTICLE_NUM-1, so there is no wrap.
- rd_count holds its value until the next sequence captures a count.

Test Plan:
- Reset check: assert rst_n=0 for 3 cycles with rd_start=1 and wr_req=1 → all outputs 0 and wr_grant=0 throughout.
- Normal stream: count word=5, words 1..5 = 0x…01..0x…05; pulse rd_start at T → reads at addresses 1..5 issued T+4..T+8; rd_out_valid T+6..T+10 with data 01..05; rd_out_last and rd_done at T+10; rd_busy falls at T+11.
- Zero count: count word=0 → no rd_out_valid; rd_done at T+4; rd_count=0.
- Clamp: count word=250 with PARTICLE_NUM=220 → rd_count=219; last issued address is 219; 219 valid beats.
- Arbitration:
  - rd_start and wr_req in the same IDLE cycle → wr_grant=0 and the read starts.
  - wr_req held through the sequence → granted at T+6+N; mem_wren=1 the next cycle with the held address/data.
  - Three consecutive writes → granted on 3 consecutive cycles.
- Mid-sequence reset: assert rst_n=0 at T+6 of an N=5 stream → next cycle all outputs 0 and IDLE; no stale rd_out_valid after release; a fresh rd_start completes normally.
